// File: rtl/dm_handshake_mem_pkg.sv
// Shared definitions for the data-memory handshake block: access sizes,
// default base address, FSM state encoding and load extension helpers.
package dm_handshake_mem_pkg;

    localparam logic [1:0]  MEM_BYTE = 2'b00;
    localparam logic [1:0]  MEM_HALF = 2'b01;
    localparam logic [1:0]  MEM_WORD = 2'b10;
    localparam logic [1:0]  MEM_RSVD = 2'b11;

    localparam logic [31:0] DATA_BASE_ADDRESS = 32'h0000_2000;

    typedef enum logic [1:0] {
        DM_ST_IDLE = 2'b00,
        DM_ST_WAIT = 2'b01,
        DM_ST_RESP = 2'b10
    } dm_state_e;

    // Extend a byte to 32 bits; sext selects sign versus zero extension.
    function automatic logic [31:0] ext_8_32(input logic [7:0] b, input logic sext);
        return {{24{sext & b[7]}}, b};
    endfunction

    // Extend a half-word to 32 bits; sext selects sign versus zero extension.
    function automatic logic [31:0] ext_16_32(input logic [15:0] h, input logic sext);
        return {{16{sext & h[15]}}, h};
    endfunction

endpackage

// File: rtl/dm_handshake_mem_lane_align.sv
// Combinational lane logic: merges store data into the old word on the
// selected byte lanes, and extracts/extends the selected lanes for loads.
module dm_lane_align
    import dm_handshake_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  op,
    input  logic [1:0]  lane,
    input  logic        ext,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    // Store merge: only the addressed lanes take new data.
    always_comb begin
        st_word = word;
        case (op)
            MEM_BYTE: begin
                case (lane)
                    2'b00:   st_word[7:0]   = wdata[7:0];
                    2'b01:   st_word[15:8]  = wdata[7:0];
                    2'b10:   st_word[23:16] = wdata[7:0];
                    2'b11:   st_word[31:24] = wdata[7:0];
                    default: st_word        = word;
                endcase
            end
            MEM_HALF: begin
                if (lane[1]) begin
                    st_word[31:16] = wdata[15:0];
                end else begin
                    st_word[15:0]  = wdata[15:0];
                end
            end
            MEM_WORD: st_word = wdata;
            default:  st_word = word;
        endcase
    end

    // Load extract: pick the addressed byte/half and extend it.
    always_comb begin
        ld_data = 32'h0000_0000;
        case (op)
            MEM_BYTE: ld_data = ext_8_32(word[{lane, 3'b000} +: 8], ext);
            MEM_HALF: begin
                if (lane[1]) begin
                    ld_data = ext_16_32(word[31:16], ext);
                end else begin
                    ld_data = ext_16_32(word[15:0], ext);
                end
            end
            MEM_WORD: ld_data = word;
            default:  ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_handshake_mem.sv
// Data memory with valid/ready request and response handshakes, one
// outstanding request, programmable response latency and error responses
// for misaligned, out-of-range and reserved accesses.
module dm_handshake_mem
    import dm_handshake_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DATA_BASE_ADDRESS,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic        req_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [1:0]  CNT_LAST  = 2'(READ_LAT - 1);

    dm_state_e      state_r;
    logic [1:0]     cnt_r;
    logic           req_ready_r;
    logic           rsp_valid_r;
    logic [31:0]    rsp_rdata_r;
    logic           rsp_err_r;
    logic [AW-1:0]  idx_r;
    logic [1:0]     lane_r;
    logic [1:0]     op_r;
    logic           ext_r;
    logic           we_r;
    logic           err_r;

    logic [31:0]    mem_r [DEPTH_WORDS];

    logic [31:0]    offset_s;
    logic [AW-1:0]  idx_s;
    logic [1:0]     lane_s;
    logic           err_s;
    logic           accept_s;
    logic           idle_s;
    logic [AW-1:0]  al_idx_s;
    logic [1:0]     al_op_s;
    logic [1:0]     al_lane_s;
    logic [31:0]    al_word_s;
    logic [31:0]    st_word_s;
    logic [31:0]    ld_data_s;

    assign offset_s = req_addr - BASE_ADDR;
    assign idx_s    = offset_s[AW+1:2];
    assign lane_s   = offset_s[1:0];
    assign idle_s   = (state_r == DM_ST_IDLE);
    assign accept_s = req_valid & req_ready_r & idle_s;

    // Request error check: range (wrap covers addresses below base), alignment, reserved op.
    always_comb begin
        err_s = 1'b0;
        if (offset_s >= MEM_BYTES) begin
            err_s = 1'b1;
        end else begin
            case (req_op)
                MEM_BYTE: err_s = 1'b0;
                MEM_HALF: err_s = lane_s[0];
                MEM_WORD: err_s = (lane_s != 2'b00);
                default:  err_s = 1'b1;
            endcase
        end
    end

    // In IDLE the aligner serves the live store; otherwise it serves the pending load.
    always_comb begin
        if (idle_s) begin
            al_idx_s  = idx_s;
            al_op_s   = req_op;
            al_lane_s = lane_s;
        end else begin
            al_idx_s  = idx_r;
            al_op_s   = op_r;
            al_lane_s = lane_r;
        end
    end

    assign al_word_s = mem_r[al_idx_s];

    dm_lane_align u_align (
        .word    (al_word_s),
        .wdata   (req_wdata),
        .op      (al_op_s),
        .lane    (al_lane_s),
        .ext     (ext_r),
        .st_word (st_word_s),
        .ld_data (ld_data_s)
    );

    // Memory array: stores commit on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && accept_s && req_we && !err_s) begin
            mem_r[idx_s] <= st_word_s;
        end
    end

    // Handshake FSM with latency counter, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= DM_ST_IDLE;
            cnt_r       <= 2'b00;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            idx_r       <= '0;
            lane_r      <= 2'b00;
            op_r        <= 2'b00;
            ext_r       <= 1'b0;
            we_r        <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                DM_ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= DM_ST_WAIT;
                        cnt_r       <= 2'b00;
                        req_ready_r <= 1'b0;
                        idx_r       <= idx_s;
                        lane_r      <= lane_s;
                        op_r        <= req_op;
                        ext_r       <= req_ext;
                        we_r        <= req_we;
                        err_r       <= err_s;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                DM_ST_WAIT: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= DM_ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= err_r;
                        rsp_rdata_r <= (we_r | err_r) ? 32'h0000_0000 : ld_data_s;
                    end else begin
                        cnt_r <= cnt_r + 2'b01;
                    end
                end
                DM_ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= DM_ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= DM_ST_IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dm_handshake_mem.sv
// Self-checking bench for dm_handshake_mem: directed scenarios plus random
// traffic against a byte-level reference model of the memory.
module tb_dm_handshake_mem;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_op;
    logic        req_ext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_rdata;
    logic        exp_err;

    dm_handshake_mem #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .READ_LAT    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_ext   (req_ext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] op, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= DEPTH * 4) return 1'b1;
        if (op == 2'd3) return 1'b1;
        if (op == 2'd1 && (off % 2) != 0) return 1'b1;
        if (op == 2'd2 && (off % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] op, input logic ext,
                                               input logic [31:0] addr);
        logic [31:0] off, w, v;
        off = addr - BASE;
        w   = mdl[off / 4];
        v   = w >> (8 * (off % 4));
        if (op == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (ext && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (op == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (ext && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata);
        logic [31:0] off, w, b;
        int n, pos;
        off = addr - BASE;
        n   = (op == 2'd0) ? 1 : ((op == 2'd1) ? 2 : 4);
        w   = mdl[off / 4];
        for (int i = 0; i < n; i++) begin
            pos = 8 * (int'(off % 4) + i);
            b   = (wdata >> (8 * i)) & 32'h0000_00FF;
            w   = (w & ~(32'h0000_00FF << pos)) | (b << pos);
        end
        mdl[off / 4] = w;
    endtask

    // Present a request and return right after the accepting edge.
    task automatic send_req(input logic we, input logic [1:0] op, input logic ext,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input string tag);
        int n;
        exp_err   = model_err(op, addr);
        exp_rdata = (we || exp_err) ? 32'h0000_0000 : model_load(op, ext, addr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_ext   = ext;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        if (we && !exp_err) model_store(op, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for the response (called at the negedge after accept) and check it.
    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, k, LAT);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    endtask

    task automatic complete_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic txn(input logic we, input logic [1:0] op, input logic ext,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        send_req(we, op, ext, addr, wdata, tag);
        wait_rsp(tag);
        complete_rsp(tag);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] addr;
        int r;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 2'b00;
        req_ext   = 1'b0;
        req_addr  = 32'h0000_0000;
        req_wdata = 32'h0000_0000;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0000_0000);
        check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;

        // Give every word a known value through the block itself.
        for (int i = 0; i < DEPTH; i++) begin
            send_req(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), $urandom, "init");
            wait_rsp("init");
            complete_rsp("init");
        end

        // Scenario 1: word store and readback.
        txn(1'b1, 2'd2, 1'b0, BASE + 32'd8, 32'hDEAD_BEEF, "s1_st");
        txn(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0000_0000, "s1_ld");
        check("s1_const", exp_rdata, 32'hDEAD_BEEF);

        // Scenario 2: byte store merge and sign-extended byte loads.
        txn(1'b1, 2'd0, 1'b0, BASE + 32'd9, 32'h1234_565A, "s2_stb");
        txn(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0000_0000, "s2_ldw");
        check("s2_w_const", exp_rdata, 32'hDEAD_5AEF);
        txn(1'b0, 2'd0, 1'b1, BASE + 32'd9, 32'h0000_0000, "s2_ldb9");
        txn(1'b0, 2'd0, 1'b1, BASE + 32'd11, 32'h0000_0000, "s2_ldb11");
        check("s2_b11_const", exp_rdata, 32'hFFFF_FFDE);

        // Scenario 3: misaligned accesses error out and leave memory untouched.
        txn(1'b0, 2'd1, 1'b0, BASE + 32'd1, 32'h0000_0000, "s3_ldh");
        txn(1'b1, 2'd2, 1'b0, BASE + 32'd6, 32'hCAFE_F00D, "s3_stw");
        txn(1'b0, 2'd2, 1'b0, BASE + 32'd4, 32'h0000_0000, "s3_rb");

        // Scenario 4: out of range, below base, reserved op.
        txn(1'b0, 2'd2, 1'b0, BASE + 32'(DEPTH * 4), 32'h0000_0000, "s4_hi");
        txn(1'b0, 2'd2, 1'b0, BASE - 32'd4, 32'h0000_0000, "s4_lo");
        txn(1'b0, 2'd3, 1'b0, BASE + 32'd16, 32'h0000_0000, "s4_rsvd");
        check("s4_err_const", {31'd0, exp_err}, 32'd1);

        // Scenario 5: response back-pressure with a waiting request.
        send_req(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0000_0000, "s5_a");
        wait_rsp("s5_a");
        held = exp_rdata;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_op    = 2'd1;
        req_ext   = 1'b1;
        req_addr  = BASE + 32'd10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s5_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("s5_hold_rdata", rsp_rdata, held);
            check("s5_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        exp_err   = model_err(2'd1, BASE + 32'd10);
        exp_rdata = model_load(2'd1, 1'b1, BASE + 32'd10);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("s5_drop_valid", {31'd0, rsp_valid}, 32'd0);
        check("s5_ready_back", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("s5_accepted", {31'd0, req_ready}, 32'd0);
        wait_rsp("s5_b");
        complete_rsp("s5_b");

        // Scenario 6: reset in WAIT keeps the committed store; reset in RESP drops the response.
        send_req(1'b1, 2'd2, 1'b0, BASE + 32'd12, 32'h1234_5678, "s6_st");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s6_wait_valid", {31'd0, rsp_valid}, 32'd0);
        check("s6_wait_ready", {31'd0, req_ready}, 32'd0);
        txn(1'b0, 2'd2, 1'b0, BASE + 32'd12, 32'h0000_0000, "s6_rb");
        check("s6_rb_const", exp_rdata, 32'h1234_5678);
        send_req(1'b0, 2'd2, 1'b0, BASE + 32'd12, 32'h0000_0000, "s6_ld");
        wait_rsp("s6_ld");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s6_resp_valid", {31'd0, rsp_valid}, 32'd0);
        check("s6_resp_ready", {31'd0, req_ready}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
            else if (r == 1) addr = BASE - 32'($urandom_range(1, 8));
            else             addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                addr, $urandom, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
